// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared store/load size encodings, FSM states and big-endian lane selection
package mips_mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    // Byte 0 sits in the most significant lane (big-endian).
    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        lane_mask = size == SZ_BYTE ? 32'hFF00_0000 >> {lane, 3'b000} :
                    size == SZ_HALF ? (lane[1] ? 32'h0000_FFFF : 32'hFFFF_0000) :
                    32'hFFFF_FFFF;
    endfunction
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        is_misaligned = size == SZ_RSVD || (size == SZ_HALF && lane[0]) ||
                        (size == SZ_WORD && lane != 2'b00);
    endfunction
endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: replaces the addressed byte/half lane of a word with truncated store data
module store_lane_merge
    import mips_mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged_word
);
    logic [31:0] rep;
    logic [31:0] mask;
    always_comb begin
        rep  = size == SZ_BYTE ? {4{new_data[7:0]}} :
               size == SZ_HALF ? {2{new_data[15:0]}} : new_data;
        mask = lane_mask(size, lane);
    end
    assign merged_word = (old_word & ~mask) | (rep & mask);
endmodule

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows register data to sb/sh/sw and writes it via read-modify-write
module store_narrow_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              done,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);
    state_t      state;
    logic [15:0] data_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] merged;

    assign st_ready = state == IDLE && !reset;

    store_lane_merge u_merge (
        .old_word    (mem_rdata),
        .new_data    ({16'h0000, data_q}),
        .size        (size_q),
        .lane        (lane_q),
        .merged_word (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            data_q     <= '0;
            size_q     <= SZ_BYTE;
            lane_q     <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: if (st_valid) begin
                    if (is_misaligned(st_size, st_addr[1:0])) begin
                        misaligned <= 1'b1;
                    end else begin
                        data_q   <= st_data[15:0];
                        size_q   <= st_size;
                        lane_q   <= st_addr[1:0];
                        mem_addr <= {st_addr[ADDR_W-1:2], 2'b00};
                        if (st_size == SZ_WORD) begin
                            state     <= WRITE;
                            mem_wr    <= 1'b1;
                            mem_wdata <= st_data;
                        end else begin
                            state  <= READ;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                READ: if (mem_ack) begin
                    state     <= WRITE;
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b1;
                    mem_wdata <= merged;
                end
                WRITE: if (mem_ack) begin
                    state  <= IDLE;
                    mem_wr <= 1'b0;
                    done   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit: directed and random stores against a byte-level memory model
module tb_store_narrow_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        st_ready, done, misaligned, mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem_m [int];

    store_narrow_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .done(done),
        .misaligned(misaligned), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] peek(input int w);
        if (!mem_m.exists(w)) mem_m[w] = $urandom;
        return mem_m[w];
    endfunction

    // Memory viewed as four big-endian bytes; a store overwrites 1, 2 or 4 of them.
    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] a,
                                                input logic [31:0] d, input logic [1:0] sz);
        logic [7:0] b [4];
        int k;
        k = int'(a & 32'd3);
        for (int i = 0; i < 4; i++) b[i] = old[31-8*i -: 8];
        if (sz == 2'd0) b[k] = d[7:0];
        else if (sz == 2'd1) begin
            b[k] = d[15:8];
            b[k+1] = d[7:0];
        end else for (int i = 0; i < 4; i++) b[i] = d[31-8*i -: 8];
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input int rw, input int ww);
        logic bad;
        logic [31:0] old, exp, wa;
        bad = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        check("ready_idle", st_ready, 1);
        st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz;
        @(negedge clk);
        st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_size = 2'($urandom);
        if (bad) begin
            check("mis_pulse", misaligned, 1);
            check("mis_rd", mem_rd, 0);
            check("mis_wr", mem_wr, 0);
            check("mis_ready", st_ready, 1);
        end else begin
            check("no_mis", misaligned, 0);
            wa = a & ~32'd3;
            old = peek(int'(a >> 2));
            exp = model_store(old, a, d, sz);
            if (sz != 2'd2) for (int c = 0; c <= rw; c++) begin
                check("rd_high", mem_rd, 1);
                check("rd_no_wr", mem_wr, 0);
                check("rd_addr", mem_addr, wa);
                mem_ack = c == rw;
                mem_rdata = c == rw ? old : $urandom;
                @(negedge clk);
                mem_ack = 1'b0;
            end
            for (int c = 0; c <= ww; c++) begin
                check("wr_high", mem_wr, 1);
                check("wr_no_rd", mem_rd, 0);
                check("wr_addr", mem_addr, wa);
                check("wr_data", mem_wdata, exp);
                check("wr_no_done", done, 0);
                mem_ack = c == ww;
                mem_rdata = $urandom;
                @(negedge clk);
                mem_ack = 1'b0;
            end
            mem_m[int'(a >> 2)] = exp;
            check("done_pulse", done, 1);
            check("done_wr_low", mem_wr, 0);
            check("done_ready", st_ready, 1);
        end
        @(negedge clk);
        check("done_single", done, 0);
        check("mis_single", misaligned, 0);
        check("idle_rd", mem_rd, 0);
        check("idle_wr", mem_wr, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", st_ready, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_done", done, 0);
        check("rst_mis", misaligned, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        @(negedge clk);
        store(32'h100, 32'hDEADBEEF, 2'd2, 0, 0);
        mem_m[32'h203 >> 2] = 32'h11223344;
        store(32'h203, 32'h123456AB, 2'd0, 0, 0);
        check("byte_mem", mem_m[32'h203 >> 2], 32'h112233AB);
        mem_m[32'h300 >> 2] = 32'hAABBCCDD;
        store(32'h302, 32'hFFFF8001, 2'd1, 0, 0);
        mem_m[32'h300 >> 2] = 32'hAABBCCDD;
        store(32'h300, 32'hFFFF8001, 2'd1, 0, 0);
        store(32'h401, 32'h12345678, 2'd1, 0, 0);
        store(32'h402, 32'h12345678, 2'd2, 0, 0);
        store(32'h400, 32'h12345678, 2'd3, 0, 0);
        store(32'h501, 32'hA5A5A5A5, 2'd0, 3, 2);
        // Reset while READ is waiting, with an ack presented on the reset edge.
        st_valid = 1'b1; st_addr = 32'h601; st_data = $urandom; st_size = 2'd0;
        @(negedge clk);
        st_valid = 1'b0;
        check("abort_rd_pre", mem_rd, 1);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        check("abort_rd", mem_rd, 0);
        check("abort_wr", mem_wr, 0);
        check("abort_done", done, 0);
        check("abort_ready", st_ready, 0);
        reset = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check("abort_idle_done", done, 0);
        check("abort_idle_wr", mem_wr, 0);
        store(32'h604, 32'hCAFEF00D, 2'd2, 1, 1);
        for (int i = 0; i < 80; i++)
            store($urandom_range(0, 255), $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
